// File: rtl/lanectrl_pause_pkg.sv
// Shared types and defaults for the lane HS clock pause scheduler.
package lanectrl_pause_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    GRANT,
    POST,
    GAP
  } state_e;

  localparam int DEF_PRE_CYCLES     = 2;
  localparam int DEF_MIN_CYCLES     = 4;
  localparam int DEF_POST_CYCLES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_CNT_W          = 7;

  function automatic bit cnt_w_ok(
    input int cnt_w,
    input int tmo,
    input int pre,
    input int post
  );
    int m;
    m = tmo;
    if (pre > m) m = pre;
    if (post > m) m = post;
    return (cnt_w < 31) && ((1 << cnt_w) > m);
  endfunction

endpackage

// File: rtl/lanectrl_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr,
// wrapping from the top requester back to zero.
module lanectrl_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lanectrl_pause_scheduler.sv
// Arbitrates HS_IO_CLK_PAUSE sessions with pre/hold/post guard
// windows and a pause-low gap between sessions.
module lanectrl_pause_scheduler
  import lanectrl_pause_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PRE_CYCLES     = DEF_PRE_CYCLES,
  parameter int MIN_CYCLES     = DEF_MIN_CYCLES,
  parameter int POST_CYCLES    = DEF_POST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic [NUM_REQ-1:0]         DONE,
  output logic [NUM_REQ-1:0]         GNT,
  output logic                       HS_IO_CLK_PAUSE,
  output logic                       BUSY,
  output logic                       TIMEOUT,
  output logic [$clog2(NUM_REQ)-1:0] GNT_ID
);

  localparam int IW = $clog2(NUM_REQ);

  if (!cnt_w_ok(CNT_W, TIMEOUT_CYCLES, PRE_CYCLES, POST_CYCLES))
  begin : g_cnt_w_chk
    $error("CNT_W too narrow for guard/timeout counts");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               pause_q, pause_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic               seen_q, seen_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic               rel;
  logic               min_ok;
  logic               hit_to;
  logic [IW-1:0]      ptr_nxt;

  lanectrl_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (REQ),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Only the latched winner's REQ/DONE bits can end a session.
  assign rel     = ~|(REQ & sel_q) | (|(DONE & sel_q)) | seen_q;
  assign min_ok  = hold_q >= CNT_W'(MIN_CYCLES);
  assign hit_to  = hold_q >= CNT_W'(TIMEOUT_CYCLES);
  assign ptr_nxt = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    pause_d = pause_q;
    seen_d  = seen_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = PRE;
          win_d   = arb_idx;
          sel_d   = arb_gnt;
          cnt_d   = CNT_W'(PRE_CYCLES - 1);
          pause_d = 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_d = GRANT;
          gnt_d   = sel_q;
          hold_d  = CNT_W'(1);
          seen_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GRANT: begin
        if (|(DONE & sel_q)) seen_d = 1'b1;
        if (hit_to || (rel && min_ok)) begin
          state_d = POST;
          gnt_d   = '0;
          cnt_d   = CNT_W'(POST_CYCLES - 1);
          tmo_d   = hit_to;
          ptr_d   = ptr_nxt;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      POST: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          pause_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      pause_q <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      pause_q <= pause_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      seen_q  <= seen_d;
    end
  end

  assign GNT             = gnt_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign BUSY            = busy_q;
  assign TIMEOUT         = tmo_q;
  assign GNT_ID          = win_q;

endmodule

// File: tb/tb_lanectrl_pause_scheduler.sv
// Self-checking bench for lanectrl_pause_scheduler against a
// session-timeline reference model.
module tb_lanectrl_pause_scheduler;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int PRE  = 2;
  localparam int MINC = 4;
  localparam int POST = 2;
  localparam int TMO  = 64;
  localparam int OW   = N + 3 + IW;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b1;
  logic [N-1:0]  REQ = '0;
  logic [N-1:0]  DONE = '0;
  logic [N-1:0]  GNT;
  logic          HS_IO_CLK_PAUSE;
  logic          BUSY;
  logic          TIMEOUT;
  logic [IW-1:0] GNT_ID;
  logic [OW-1:0] obs;

  lanectrl_pause_scheduler #(
    .NUM_REQ        (N),
    .PRE_CYCLES     (PRE),
    .MIN_CYCLES     (MINC),
    .POST_CYCLES    (POST),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (7)
  ) dut (
    .CLK             (CLK),
    .RESETN          (RESETN),
    .REQ             (REQ),
    .DONE            (DONE),
    .GNT             (GNT),
    .HS_IO_CLK_PAUSE (HS_IO_CLK_PAUSE),
    .BUSY            (BUSY),
    .TIMEOUT         (TIMEOUT),
    .GNT_ID          (GNT_ID)
  );

  always #5 CLK = ~CLK;

  assign obs = {GNT, HS_IO_CLK_PAUSE, BUSY, TIMEOUT, GNT_ID};

  int checks = 0;
  int errors = 0;

  // Session timeline model: a session starts at edge m_start, grant
  // spans [m_start+PRE, m_gend), pause spans [m_start, m_gend+POST).
  int n = 0;
  bit m_active = 0;
  int m_win = 0;
  int m_ptr = 0;
  int m_start = 0;
  int m_gend = -1;
  bit m_seen = 0;
  bit m_to = 0;

  function automatic void model_reset();
    m_active = 0;
    m_win    = 0;
    m_ptr    = 0;
    m_gend   = -1;
    m_seen   = 0;
    m_to     = 0;
  endfunction

  function automatic void model_step(logic [N-1:0] rq, logic [N-1:0] dn);
    int held;
    bit rel;
    if (!m_active) begin
      if (rq != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (rq[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        m_start  = n;
        m_gend   = -1;
        m_seen   = 0;
        m_to     = 0;
        m_active = 1;
      end
    end else if (m_gend < 0 && n > m_start + PRE) begin
      held = n - m_start - PRE;
      rel  = !rq[m_win] || dn[m_win] || m_seen;
      if (dn[m_win]) m_seen = 1;
      if (held >= TMO || (rel && held >= MINC)) begin
        m_gend = n;
        m_to   = (held >= TMO);
        m_ptr  = (m_win + 1) % N;
      end
    end else if (m_gend >= 0 && n >= m_gend + POST + 1) begin
      m_active = 0;
    end
  endfunction

  function automatic logic [OW-1:0] exp_out();
    logic [N-1:0] g;
    logic p, b, t;
    g = '0;
    p = 1'b0;
    b = 1'b0;
    if (m_active) begin
      p = (n >= m_start) && (m_gend < 0 || n < m_gend + POST);
      if (n >= m_start + PRE && (m_gend < 0 || n < m_gend)) g[m_win] = 1'b1;
      b = (m_gend < 0 || n < m_gend + POST + 1);
    end
    t = m_to && (n == m_gend);
    return {g, p, b, t, IW'(m_win)};
  endfunction

  task automatic tick();
    n++;
    model_step(REQ, DONE);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2 RESETN = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, {OW{1'b0}});
    end
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #3 RESETN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL reset_idle n=%0d got=%h exp=%h", n, obs, exp_out());
      end
    end
  endtask

  task automatic test_round_robin();
    int order[5];
    int got = 0;
    int low = 0;
    int minlow = 1000;
    logic prev_p = 1'b0;
    logic [N-1:0] prev_g = '0;
    REQ = '1;
    for (int c = 0; c < 200 && got < 5; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL rr n=%0d got=%h exp=%h", n, obs, exp_out());
      end
      if (HS_IO_CLK_PAUSE && !prev_p && got > 0 && low < minlow) minlow = low;
      low = HS_IO_CLK_PAUSE ? 0 : low + 1;
      DONE = '0;
      if (GNT != '0 && prev_g == '0) begin
        order[got] = int'(GNT_ID);
        got++;
        DONE = GNT;
        if (got == 5) REQ = '0;
      end
      prev_p = HS_IO_CLK_PAUSE;
      prev_g = GNT;
    end
    tick();
    DONE = '0;
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=5", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (order[i] != i % N) begin
        errors++;
        $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, order[i], i % N);
      end
    end
    checks++;
    if (minlow < 2) begin
      errors++;
      $display("FAIL rr_gap got=%0d exp>=2", minlow);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL rr_drain n=%0d got=%h exp=%h", n, obs, exp_out());
      end
    end
  endtask

  task automatic test_single();
    int pc = 0;
    int gc = 0;
    REQ = 4'b0010;
    for (int c = 1; c <= 18; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL single n=%0d got=%h exp=%h", n, obs, exp_out());
      end
      if (HS_IO_CLK_PAUSE) pc++;
      if (GNT == 4'b0010) gc++;
      if (c == 10) DONE = 4'b0010;
      if (c == 11) begin
        DONE = '0;
        REQ  = '0;
      end
    end
    checks++;
    if (pc != PRE + 8 + POST) begin
      errors++;
      $display("FAIL single_pause_len got=%0d exp=%0d", pc, PRE + 8 + POST);
    end
    checks++;
    if (gc != 8) begin
      errors++;
      $display("FAIL single_gnt_len got=%0d exp=8", gc);
    end
  endtask

  task automatic test_early_done();
    int gc = 0;
    int rise = -10;
    logic [N-1:0] prev_g = '0;
    REQ = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL early n=%0d got=%h exp=%h", n, obs, exp_out());
      end
      if (GNT == 4'b0100) gc++;
      if (GNT != '0 && prev_g == '0) rise = c;
      if (c == rise + 1) DONE = 4'b0100;
      if (c == rise + 2) begin
        DONE = '0;
        REQ  = '0;
      end
      prev_g = GNT;
    end
    checks++;
    if (gc != MINC) begin
      errors++;
      $display("FAIL early_gnt_len got=%0d exp=%0d", gc, MINC);
    end
  endtask

  task automatic test_timeout();
    int gc = 0;
    int tc = 0;
    REQ = 4'b0001;
    for (int c = 1; c <= 100; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL tmo n=%0d got=%h exp=%h", n, obs, exp_out());
      end
      if (GNT == 4'b0001) gc++;
      if (TIMEOUT) begin
        tc++;
        REQ = '0;
      end
    end
    checks++;
    if (gc != TMO) begin
      errors++;
      $display("FAIL tmo_gnt_len got=%0d exp=%0d", gc, TMO);
    end
    checks++;
    if (tc != 1) begin
      errors++;
      $display("FAIL tmo_pulses got=%0d exp=1", tc);
    end
    REQ = '1;
    tick();
    REQ = '0;
    checks++;
    if (GNT_ID !== IW'(1)) begin
      errors++;
      $display("FAIL tmo_ptr_adv got=%0d exp=1", GNT_ID);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL tmo_drain n=%0d got=%h exp=%h", n, obs, exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    int c;
    REQ = '1;
    c = 0;
    while (GNT == '0 && c < 10) begin
      tick();
      c++;
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL areset_pre n=%0d got=%h exp=%h", n, obs, exp_out());
      end
    end
    checks++;
    if (GNT == '0) begin
      errors++;
      $display("FAIL areset_wait got=%h exp=nonzero", GNT);
    end
    #2 RESETN = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL areset_now got=%h exp=%h", obs, {OW{1'b0}});
    end
    model_reset();
    @(posedge CLK);
    #3 RESETN = 1'b1;
    c = 0;
    while (GNT == '0 && c < 10) begin
      tick();
      c++;
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL areset_post n=%0d got=%h exp=%h", n, obs, exp_out());
      end
    end
    REQ = '0;
    checks++;
    if (GNT !== 4'b0001 || GNT_ID !== IW'(0)) begin
      errors++;
      $display("FAIL areset_restart got=%h/%0d exp=0001/0", GNT, GNT_ID);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL areset_drain n=%0d got=%h exp=%h", n, obs, exp_out());
      end
    end
  endtask

  task automatic test_withdraw();
    int gc = 0;
    logic [N-1:0] prev_g = '0;
    REQ = 4'b1000;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL wdraw n=%0d got=%h exp=%h", n, obs, exp_out());
      end
      if (GNT == 4'b1000) gc++;
      DONE = '0;
      if (c == 1) begin
        REQ  = '0;
        DONE = 4'b0111;
      end
      if (GNT != '0 && prev_g == '0) begin
        DONE = 4'b0001;
        checks++;
        if (GNT_ID !== IW'(3)) begin
          errors++;
          $display("FAIL wdraw_id got=%0d exp=3", GNT_ID);
        end
      end
      prev_g = GNT;
    end
    checks++;
    if (gc != MINC) begin
      errors++;
      $display("FAIL wdraw_gnt_len got=%0d exp=%0d", gc, MINC);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL random n=%0d got=%h exp=%h", n, obs, exp_out());
      end
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 11) == 0) REQ[b] = ~REQ[b];
      DONE = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
    end
    REQ  = '0;
    DONE = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL random_drain n=%0d got=%h exp=%h", n, obs, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_early_done();
    test_timeout();
    test_async_reset();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
